// File: rtl/fir_mac_sched.sv
// Sequencer for the 64-tap FIR MAC datapath: coefficient load, sample admission,
// tap stepping and result strobe. Every output is a register.
module fir_mac_sched #(
  parameter int unsigned NTAPS   = 64,
  parameter int unsigned AW      = 6,
  parameter int unsigned DW      = 16,
  parameter int unsigned MAC_LAT = 2
) (
  input  logic          clk1,
  input  logic          CTRL_rest,
  input  logic          start_load,
  input  logic [DW-1:0] coef_in,
  input  logic          coef_valid,
  output logic          coef_ready,
  output logic          coef_we,
  output logic [AW-1:0] coef_waddr,
  output logic [DW-1:0] coef_wdata,
  output logic          coefs_loaded,
  input  logic [DW-1:0] x_in,
  input  logic          x_valid,
  output logic          x_ready,
  output logic          fifo_shift,
  output logic [DW-1:0] x_data,
  output logic [AW-1:0] tap_addr,
  output logic          mac_en,
  output logic          mac_clr,
  output logic          mac_last,
  output logic          y_valid,
  output logic [15:0]   sample_cnt
);

  localparam int unsigned DCW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [AW-1:0]  LAST_TAP   = AW'(NTAPS - 1);
  localparam logic [AW-1:0]  PRE_LAST   = AW'(NTAPS - 2);
  localparam logic [DCW-1:0] DRAIN_INIT = DCW'(MAC_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_X,
    S_MAC,
    S_DRAIN
  } state_t;

  state_t         state;
  logic [AW-1:0]  cnt;
  logic [DCW-1:0] drain_cnt;

  always_ff @(posedge clk1) begin
    if (CTRL_rest) begin
      state        <= S_IDLE;
      cnt          <= '0;
      drain_cnt    <= '0;
      coef_ready   <= 1'b0;
      coef_we      <= 1'b0;
      coef_waddr   <= '0;
      coef_wdata   <= '0;
      coefs_loaded <= 1'b0;
      x_ready      <= 1'b0;
      fifo_shift   <= 1'b0;
      x_data       <= '0;
      tap_addr     <= '0;
      mac_en       <= 1'b0;
      mac_clr      <= 1'b0;
      mac_last     <= 1'b0;
      y_valid      <= 1'b0;
      sample_cnt   <= '0;
    end else begin
      coef_we    <= 1'b0;
      fifo_shift <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_load) begin
            state      <= S_LOAD;
            cnt        <= '0;
            coef_ready <= 1'b1;
          end
        end
        S_LOAD: begin
          if (start_load) begin
            cnt <= '0;
          end else if (coef_valid && coef_ready) begin
            coef_we    <= 1'b1;
            coef_waddr <= cnt;
            coef_wdata <= coef_in;
            if (cnt == LAST_TAP) begin
              coef_ready   <= 1'b0;
              coefs_loaded <= 1'b1;
              x_ready      <= 1'b1;
              state        <= S_WAIT_X;
            end else begin
              cnt <= cnt + AW'(1);
            end
          end
        end
        // A reload request wins over a sample offered in the same cycle
        S_WAIT_X: begin
          if (start_load) begin
            state        <= S_LOAD;
            cnt          <= '0;
            coef_ready   <= 1'b1;
            coefs_loaded <= 1'b0;
            x_ready      <= 1'b0;
          end else if (x_valid && x_ready) begin
            x_ready    <= 1'b0;
            fifo_shift <= 1'b1;
            x_data     <= x_in;
            tap_addr   <= '0;
            state      <= S_MAC;
          end
        end
        // First MAC-state cycle lets the delay line shift before tap 0 is read
        S_MAC: begin
          if (!mac_en) begin
            mac_en   <= 1'b1;
            mac_clr  <= 1'b1;
            mac_last <= (NTAPS == 1);
            tap_addr <= '0;
          end else if (tap_addr == LAST_TAP) begin
            mac_en    <= 1'b0;
            mac_clr   <= 1'b0;
            mac_last  <= 1'b0;
            tap_addr  <= '0;
            drain_cnt <= DRAIN_INIT;
            state     <= S_DRAIN;
            if (MAC_LAT == 1) begin
              y_valid    <= 1'b1;
              sample_cnt <= sample_cnt + 16'd1;
            end
          end else begin
            tap_addr <= tap_addr + AW'(1);
            mac_clr  <= 1'b0;
            mac_last <= (tap_addr == PRE_LAST);
          end
        end
        S_DRAIN: begin
          if (drain_cnt == '0) begin
            y_valid <= 1'b0;
            x_ready <= 1'b1;
            state   <= S_WAIT_X;
          end else begin
            drain_cnt <= drain_cnt - DCW'(1);
            if (drain_cnt == DCW'(1)) begin
              y_valid    <= 1'b1;
              sample_cnt <= sample_cnt + 16'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_sched.sv
// Bench for fir_mac_sched: timeline model of the expected outputs checked every cycle,
// plus literal expectations for load, latency, spacing, reset abort, reload priority, wrap.
module tb_fir_mac_sched;

  localparam int NTAPS   = 64;
  localparam int MAC_LAT = 2;
  localparam int K_Y     = NTAPS + MAC_LAT + 1;

  localparam int MD_IDLE  = 0;
  localparam int MD_LOAD  = 1;
  localparam int MD_WAITX = 2;
  localparam int MD_BUSY  = 3;

  logic        clk1 = 1'b0;
  logic        CTRL_rest = 1'b1;
  logic        start_load = 1'b0;
  logic [15:0] coef_in = '0;
  logic        coef_valid = 1'b0;
  logic        coef_ready;
  logic        coef_we;
  logic [5:0]  coef_waddr;
  logic [15:0] coef_wdata;
  logic        coefs_loaded;
  logic [15:0] x_in = '0;
  logic        x_valid = 1'b0;
  logic        x_ready;
  logic        fifo_shift;
  logic [15:0] x_data;
  logic [5:0]  tap_addr;
  logic        mac_en;
  logic        mac_clr;
  logic        mac_last;
  logic        y_valid;
  logic [15:0] sample_cnt;

  always #5 clk1 = ~clk1;

  fir_mac_sched dut (
    .clk1         (clk1),
    .CTRL_rest    (CTRL_rest),
    .start_load   (start_load),
    .coef_in      (coef_in),
    .coef_valid   (coef_valid),
    .coef_ready   (coef_ready),
    .coef_we      (coef_we),
    .coef_waddr   (coef_waddr),
    .coef_wdata   (coef_wdata),
    .coefs_loaded (coefs_loaded),
    .x_in         (x_in),
    .x_valid      (x_valid),
    .x_ready      (x_ready),
    .fifo_shift   (fifo_shift),
    .x_data       (x_data),
    .tap_addr     (tap_addr),
    .mac_en       (mac_en),
    .mac_clr      (mac_clr),
    .mac_last     (mac_last),
    .y_valid      (y_valid),
    .sample_cnt   (sample_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;
  bit force_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Model: mode plus cycles elapsed since the accept cycle
  int          m_mode = MD_IDLE;
  int          m_k = 0;
  int          m_cnt = 0;
  logic        m_loaded = 1'b0;
  logic [15:0] m_samples = '0;
  logic        m_we = 1'b0;
  logic [5:0]  m_waddr = '0;
  logic [15:0] m_wdata = '0;
  logic [15:0] m_xdata = '0;

  // Observation counters taken from the DUT
  int          cyc = 0;
  int          n_we = 0, n_shift = 0, n_mac = 0, n_clr = 0, n_last = 0, n_y = 0, n_acc = 0;
  int          acc_cyc = 0, y_cyc = 0, spacing = 0;
  logic [5:0]  tap_clr = '0, tap_last = '0, last_waddr = '0;
  logic [15:0] last_wdata = '0;

  always @(negedge clk1) begin
    bit busy, e_shift, e_mac, e_clr, e_last, e_y;
    if (force_on) m_samples = 16'hFFFF;
    busy    = (m_mode == MD_BUSY);
    e_shift = busy && (m_k == 1);
    e_mac   = busy && (m_k >= 2) && (m_k <= NTAPS + 1);
    e_clr   = busy && (m_k == 2);
    e_last  = busy && (m_k == NTAPS + 1);
    e_y     = busy && (m_k == K_Y);
    if (chk_en) begin
      chk("coef_ready",   32'(coef_ready),   32'(m_mode == MD_LOAD));
      chk("x_ready",      32'(x_ready),      32'(m_mode == MD_WAITX));
      chk("coefs_loaded", 32'(coefs_loaded), 32'(m_loaded));
      chk("coef_we",      32'(coef_we),      32'(m_we));
      chk("coef_waddr",   32'(coef_waddr),   32'(m_waddr));
      chk("coef_wdata",   32'(coef_wdata),   32'(m_wdata));
      chk("fifo_shift",   32'(fifo_shift),   32'(e_shift));
      chk("x_data",       32'(x_data),       32'(m_xdata));
      chk("mac_en",       32'(mac_en),       32'(e_mac));
      chk("mac_clr",      32'(mac_clr),      32'(e_clr));
      chk("mac_last",     32'(mac_last),     32'(e_last));
      chk("y_valid",      32'(y_valid),      32'(e_y));
      chk("sample_cnt",   32'(sample_cnt),   32'(m_samples));
      if (e_mac) chk("tap_addr", 32'(tap_addr), 32'(m_k - 2));
    end

    if (coef_we) begin n_we++; last_waddr = coef_waddr; last_wdata = coef_wdata; end
    if (fifo_shift) n_shift++;
    if (mac_en) n_mac++;
    if (mac_clr) begin n_clr++; tap_clr = tap_addr; end
    if (mac_last) begin n_last++; tap_last = tap_addr; end
    if (y_valid) begin n_y++; y_cyc = cyc; end
    if (x_valid && x_ready && !start_load && !CTRL_rest) begin
      if (n_acc > 0) spacing = cyc - acc_cyc;
      acc_cyc = cyc;
      n_acc++;
    end

    m_we = 1'b0;
    if (CTRL_rest) begin
      m_mode = MD_IDLE; m_k = 0; m_cnt = 0; m_loaded = 1'b0; m_samples = '0;
      m_waddr = '0; m_wdata = '0; m_xdata = '0;
    end else begin
      case (m_mode)
        MD_IDLE: if (start_load) begin m_mode = MD_LOAD; m_cnt = 0; end
        MD_LOAD: begin
          if (start_load) begin
            m_cnt = 0;
          end else if (coef_valid) begin
            m_we = 1'b1; m_waddr = 6'(m_cnt); m_wdata = coef_in;
            if (m_cnt == NTAPS - 1) begin m_mode = MD_WAITX; m_loaded = 1'b1; end
            else m_cnt++;
          end
        end
        MD_WAITX: begin
          if (start_load) begin
            m_mode = MD_LOAD; m_cnt = 0; m_loaded = 1'b0;
          end else if (x_valid) begin
            m_mode = MD_BUSY; m_k = 1; m_xdata = x_in;
          end
        end
        default: begin
          if (m_k == K_Y) m_mode = MD_WAITX;
          else begin
            m_k++;
            if (m_k == K_Y) m_samples = m_samples + 16'd1;
          end
        end
      endcase
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic load_coefs(input int gap_mod);
    logic acc;
    int   t;
    start_load = 1'b1;
    tick();
    start_load = 1'b0;
    for (int i = 0; i < NTAPS; i++) begin
      coef_in = 16'(i + 1);
      coef_valid = 1'b1;
      acc = 1'b0;
      t = 0;
      while (!acc && t < 20) begin
        @(negedge clk1);
        acc = coef_ready;
        tick();
        t++;
      end
      if (!acc) chk("coef_accept_wait", 32'(acc), 32'd1);
      coef_valid = 1'b0;
      if (gap_mod != 0 && (i % gap_mod) == 0) tick();
    end
  endtask

  task automatic send_x(input logic [15:0] v);
    logic acc;
    int   t;
    x_in = v;
    x_valid = 1'b1;
    acc = 1'b0;
    t = 0;
    while (!acc && t < 200) begin
      @(negedge clk1);
      acc = x_ready;
      tick();
      t++;
    end
    if (!acc) chk("x_accept_wait", 32'(acc), 32'd1);
    x_valid = 1'b0;
  endtask

  task automatic wait_y(input int target);
    for (int t = 0; t < 300 && n_y < target; t++) tick();
    chk("y_wait", n_y, target);
  endtask

  int b_we, b_shift, b_mac, b_clr, b_last, b_y, b_acc;

  initial begin
    tick();
    chk_en = 1'b1;
    tick();
    CTRL_rest = 1'b0;
    chk("rst_sample_cnt", 32'(sample_cnt), 32'd0);
    chk("rst_coefs_loaded", 32'(coefs_loaded), 32'd0);
    chk("rst_ready", 32'({coef_ready, x_ready, y_valid, mac_en}), 32'd0);

    // Coefficient load with valid gaps
    b_we = n_we;
    load_coefs(3);
    tick(); tick();
    chk("load_we_count", n_we - b_we, 64);
    chk("load_last_waddr", 32'(last_waddr), 32'd63);
    chk("load_last_wdata", 32'(last_wdata), 32'd64);
    chk("load_coefs_loaded", 32'(coefs_loaded), 32'd1);
    chk("load_coef_ready_low", 32'(coef_ready), 32'd0);

    // Single sample
    b_shift = n_shift; b_mac = n_mac; b_clr = n_clr; b_last = n_last; b_y = n_y;
    send_x(16'h4000);
    wait_y(b_y + 1);
    chk("t3_latency", y_cyc - acc_cyc, 67);
    chk("t3_shift_count", n_shift - b_shift, 1);
    chk("t3_mac_cycles", n_mac - b_mac, 64);
    chk("t3_clr_count", n_clr - b_clr, 1);
    chk("t3_last_count", n_last - b_last, 1);
    chk("t3_clr_tap", 32'(tap_clr), 32'd0);
    chk("t3_last_tap", 32'(tap_last), 32'd63);
    chk("t3_sample_cnt", 32'(sample_cnt), 32'd1);

    // Reset in the middle of a MAC run
    b_y = n_y;
    send_x(16'h1234);
    repeat (20) tick();
    CTRL_rest = 1'b1;
    repeat (3) tick();
    CTRL_rest = 1'b0;
    repeat (80) tick();
    chk("t1_no_y", n_y - b_y, 0);
    chk("t1_sample_cnt", 32'(sample_cnt), 32'd0);
    chk("t1_coefs_loaded", 32'(coefs_loaded), 32'd0);
    chk("t1_idle_ready", 32'({coef_ready, x_ready}), 32'd0);

    // Back-to-back samples, stray coef_valid outside LOAD
    load_coefs(0);
    tick();
    b_y = n_y; b_acc = n_acc; b_we = n_we;
    coef_valid = 1'b1;
    x_valid = 1'b1;
    for (int t = 0; t < 400 && n_acc < b_acc + 3; t++) begin
      x_in = 16'(16'h0100 + n_acc);
      tick();
    end
    x_valid = 1'b0;
    chk("t4_accepts", n_acc - b_acc, 3);
    chk("t4_spacing", spacing, 68);
    wait_y(b_y + 3);
    coef_valid = 1'b0;
    chk("t4_sample_cnt", 32'(sample_cnt), 32'd3);
    chk("t4_no_stray_we", n_we - b_we, 0);

    // Reload request collides with a sample
    chk("t5_pre_x_ready", 32'(x_ready), 32'd1);
    b_shift = n_shift;
    start_load = 1'b1;
    x_valid = 1'b1;
    x_in = 16'h7777;
    tick();
    start_load = 1'b0;
    x_valid = 1'b0;
    chk("t5_coef_ready", 32'(coef_ready), 32'd1);
    chk("t5_coefs_loaded", 32'(coefs_loaded), 32'd0);
    chk("t5_x_ready", 32'(x_ready), 32'd0);
    tick(); tick();
    chk("t5_no_shift", n_shift - b_shift, 0);

    // sample_cnt wrap
    load_coefs(0);
    tick();
    force dut.sample_cnt = 16'hFFFF;
    force_on = 1'b1;
    tick();
    release dut.sample_cnt;
    force_on = 1'b0;
    tick();
    chk("t6_preload", 32'(sample_cnt), 32'h0000FFFF);
    b_y = n_y;
    send_x(16'h0001);
    wait_y(b_y + 1);
    chk("t6_wrap", 32'(sample_cnt), 32'd0);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
